// File: rtl/snoop_bus_ctrl_if.sv
// Cache-side bundle of the snooping bus: per-cache request/response/address/data
// lanes into the controller, and snoop/completion lanes back out to the caches.
interface snoop_bus_ctrl_if #(
  parameter int NUM_CACHE  = 4,
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 32
);
  localparam int LA = ADDR_WIDTH - $clog2(LINE_WIDTH / 8);

  logic [2*NUM_CACHE-1:0]          cac2bus_bus_req;
  logic [2*NUM_CACHE-1:0]          cac2bus_bus_rsp;
  logic [LA*NUM_CACHE-1:0]         cac2bus_addr;
  logic [LINE_WIDTH*NUM_CACHE-1:0] cac2bus_data;
  logic [NUM_CACHE-1:0]            cac2bus_write_back;

  logic [2*NUM_CACHE-1:0]          bus2cac_bus_req;
  logic [2*NUM_CACHE-1:0]          bus2cac_bus_rsp;
  logic [LA-1:0]                   bus2cac_addr;
  logic [LINE_WIDTH-1:0]           bus2cac_data;

  modport master (
    input  cac2bus_bus_req, cac2bus_bus_rsp, cac2bus_addr, cac2bus_data, cac2bus_write_back,
    output bus2cac_bus_req, bus2cac_bus_rsp, bus2cac_addr, bus2cac_data
  );

  modport slave (
    output cac2bus_bus_req, cac2bus_bus_rsp, cac2bus_addr, cac2bus_data, cac2bus_write_back,
    input  bus2cac_bus_req, bus2cac_bus_rsp, bus2cac_addr, bus2cac_data
  );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// Shared snooping-bus controller: round-robin arbitration (write-backs first),
// snoop broadcast, response collection, memory read/write-back, completion handshake.
module snoop_bus_ctrl #(
  parameter int  NUM_CACHE  = 4,
  parameter int  LINE_WIDTH = 512,
  parameter int  ADDR_WIDTH = 32,
  localparam int LA         = ADDR_WIDTH - $clog2(LINE_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  snoop_bus_ctrl_if.master      bus,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [LA-1:0]         mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);
  localparam int IW = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;

  localparam logic [1:0] REQ_RD    = 2'b01;
  localparam logic [1:0] REQ_UPGR  = 2'b11;
  localparam logic [1:0] RSP_HIT   = 2'b10;
  localparam logic [1:0] RSP_FLUSH = 2'b11;

  typedef enum logic [2:0] {IDLE, SNOOP, COLLECT, MEM_WB, MEM_RD, RESP} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         ptr, win, arb_idx;
  logic [1:0]            wtype, rsp_code;
  logic                  is_wb, flush_seen, hit_seen;
  logic [LA-1:0]         addr;
  logic [LINE_WIDTH-1:0] line;
  logic [NUM_CACHE-1:0]  seen;
  logic                  arb_found, arb_wb, all_done, win_release;

  function automatic int unsigned rr(input logic [IW-1:0] p, input int unsigned k);
    return (32'(p) + k) % NUM_CACHE;
  endfunction

  // Two passes from the pointer: the write-back class strictly outranks requests.
  always_comb begin
    arb_found = 1'b0;
    arb_wb    = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NUM_CACHE; k++) begin
      if (!arb_found && bus.cac2bus_write_back[rr(ptr, k)]) begin
        arb_found = 1'b1;
        arb_wb    = 1'b1;
        arb_idx   = IW'(rr(ptr, k));
      end
    end
    for (int unsigned k = 0; k < NUM_CACHE; k++) begin
      if (!arb_found && bus.cac2bus_bus_req[2*rr(ptr, k) +: 2] != 2'b00) begin
        arb_found = 1'b1;
        arb_idx   = IW'(rr(ptr, k));
      end
    end
  end

  always_comb begin
    all_done = 1'b1;
    for (int unsigned k = 0; k < NUM_CACHE; k++) begin
      if (32'(win) != k && !seen[k]) all_done = 1'b0;
    end
    win_release = is_wb ? !bus.cac2bus_write_back[win]
                        : (bus.cac2bus_bus_req[2*32'(win) +: 2] == 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_found) state_nxt = arb_wb ? MEM_WB : SNOOP;
      SNOOP:   state_nxt = COLLECT;
      COLLECT: if (all_done) state_nxt = flush_seen ? MEM_WB :
                                         (wtype == REQ_UPGR) ? RESP : MEM_RD;
      MEM_WB:  if (mem_ready) state_nxt = RESP;
      MEM_RD:  if (mem_ready) state_nxt = RESP;
      RESP:    if (win_release) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      win        <= '0;
      wtype      <= '0;
      is_wb      <= 1'b0;
      addr       <= '0;
      line       <= '0;
      seen       <= '0;
      flush_seen <= 1'b0;
      hit_seen   <= 1'b0;
      rsp_code   <= '0;
    end else begin
      case (state)
        IDLE: if (arb_found) begin
          win        <= arb_idx;
          is_wb      <= arb_wb;
          wtype      <= arb_wb ? 2'b00 : bus.cac2bus_bus_req[2*32'(arb_idx) +: 2];
          addr       <= bus.cac2bus_addr[LA*32'(arb_idx) +: LA];
          line       <= bus.cac2bus_data[LINE_WIDTH*32'(arb_idx) +: LINE_WIDTH];
          seen       <= '0;
          flush_seen <= 1'b0;
          hit_seen   <= 1'b0;
          rsp_code   <= 2'b01;
        end
        COLLECT: begin
          for (int unsigned k = 0; k < NUM_CACHE; k++) begin
            if (32'(win) != k && !seen[k] && bus.cac2bus_bus_rsp[2*k +: 2] != 2'b00) begin
              seen[k] <= 1'b1;
              if (bus.cac2bus_bus_rsp[2*k +: 2] == RSP_FLUSH) begin
                flush_seen <= 1'b1;
                line       <= bus.cac2bus_data[LINE_WIDTH*k +: LINE_WIDTH];
              end
              if (bus.cac2bus_bus_rsp[2*k +: 2] == RSP_HIT) hit_seen <= 1'b1;
            end
          end
          if (all_done) begin
            if (flush_seen || wtype == REQ_UPGR) rsp_code <= 2'b11;
            else if (hit_seen && wtype == REQ_RD) rsp_code <= 2'b10;
            else                                  rsp_code <= 2'b01;
          end
        end
        MEM_RD: if (mem_ready) line <= mem_rdata;
        RESP:   if (win_release) ptr <= IW'((32'(win) + 32'd1) % NUM_CACHE);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.bus2cac_bus_req = '0;
    bus.bus2cac_bus_rsp = '0;
    bus.bus2cac_addr    = '0;
    bus.bus2cac_data    = '0;
    mem_rd              = 1'b0;
    mem_wr              = 1'b0;
    mem_addr            = '0;
    mem_wdata           = '0;
    if (state != IDLE) bus.bus2cac_addr = addr;
    case (state)
      SNOOP, COLLECT: begin
        for (int unsigned k = 0; k < NUM_CACHE; k++) begin
          if (32'(win) != k) bus.bus2cac_bus_req[2*k +: 2] = wtype;
        end
      end
      MEM_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = addr;
        mem_wdata = line;
      end
      MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = addr;
      end
      RESP: begin
        bus.bus2cac_bus_rsp[2*32'(win) +: 2] = rsp_code;
        bus.bus2cac_data                     = line;
      end
      default: ;
    endcase
  end
endmodule
